// File: rtl/round_robin_n_pkg.sv
// Shared types and helpers for the N-port round-robin burst arbiter.
package round_robin_n_pkg;

  // Arbiter FSM: IDLE arbitrates every cycle, BURST holds one port.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  // Ceiling log2, never below 1 so select buses are at least one bit wide.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) res = i + 1;
    end
    return (res == 0) ? 1 : res;
  endfunction

endpackage

// File: rtl/round_robin_n_pick.sv
// Rotating priority search: first set request bit after ptr, wrapping through ptr.
module rr_priority_pick
  import round_robin_n_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned SEL_W     = clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] request_i,
  input  logic [SEL_W-1:0]     ptr_i,
  output logic                 found_o,
  output logic [SEL_W-1:0]     idx_o,
  output logic [NUM_PORTS-1:0] onehot_o
);

  int unsigned      cand;
  logic [SEL_W-1:0] cand_idx;

  // Walk the ports in priority order; the first requester wins.
  always_comb begin
    found_o  = 1'b0;
    idx_o    = '0;
    onehot_o = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      cand     = (32'(ptr_i) + k) % NUM_PORTS;
      cand_idx = SEL_W'(cand);
      if (!found_o && request_i[cand_idx]) begin
        found_o  = 1'b1;
        idx_o    = cand_idx;
        onehot_o = NUM_PORTS'(1) << cand_idx;
      end
    end
  end

endmodule

// File: rtl/round_robin_n.sv
// N-port round-robin FIFO arbiter with weighted bursts and downstream backpressure.
module round_robin_n
  import round_robin_n_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned SEL_W     = clog2(NUM_PORTS),
  parameter int unsigned BURST_W   = 3
) (
  input  logic                         clk,
  input  logic                         reset_L,
  input  logic [NUM_PORTS-1:0]         request,
  input  logic [NUM_PORTS*BURST_W-1:0] burst_cfg,
  input  logic                         mode,
  input  logic                         dest_ready,
  output logic [NUM_PORTS-1:0]         pop,
  output logic [SEL_W-1:0]             port_mux,
  output logic                         valid_mux,
  output logic                         grant_active
);

  localparam int unsigned      CNT_W   = BURST_W + 1;
  localparam logic [SEL_W-1:0] PTR_RST = SEL_W'(NUM_PORTS - 1);

  state_e                 state_q, state_d;
  logic [SEL_W-1:0]       ptr_q, ptr_d;
  logic [SEL_W-1:0]       grant_q, grant_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       len_q, len_d;
  logic [SEL_W-1:0]       port_mux_q;
  logic                   valid_mux_q;
  logic                   grant_active_q;

  logic                   pick_found;
  logic [SEL_W-1:0]       pick_idx;
  logic [NUM_PORTS-1:0]   pick_onehot;
  logic [BURST_W-1:0]     cfg_field_c;
  logic [CNT_W-1:0]       new_len_c;
  logic [CNT_W-1:0]       cnt_inc_c;
  logic [NUM_PORTS-1:0]   pop_c;
  logic [SEL_W-1:0]       pop_idx_c;

  rr_priority_pick #(
    .NUM_PORTS (NUM_PORTS),
    .SEL_W     (SEL_W)
  ) u_pick (
    .request_i (request),
    .ptr_i     (ptr_q),
    .found_o   (pick_found),
    .idx_o     (pick_idx),
    .onehot_o  (pick_onehot)
  );

  // Burst length of the candidate port; zero fields and classic mode mean one pop.
  always_comb begin
    cfg_field_c = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (SEL_W'(i) == pick_idx) cfg_field_c = burst_cfg[i*BURST_W +: BURST_W];
    end
    new_len_c = (mode && (cfg_field_c != '0)) ? CNT_W'(cfg_field_c) : CNT_W'(1);
    cnt_inc_c = cnt_q + CNT_W'(1);
  end

  // Next-state and pop decode.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    pop_c     = '0;
    pop_idx_c = grant_q;
    case (state_q)
      ST_IDLE: begin
        if (dest_ready && pick_found) begin
          pop_c     = pick_onehot;
          pop_idx_c = pick_idx;
          len_d     = new_len_c;
          if (new_len_c == CNT_W'(1)) begin
            ptr_d = pick_idx;
          end else begin
            state_d = ST_BURST;
            grant_d = pick_idx;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      ST_BURST: begin
        if (!request[grant_q]) begin
          // Held port emptied: abandon the burst without a pop.
          state_d = ST_IDLE;
          ptr_d   = grant_q;
        end else if (dest_ready) begin
          pop_c = NUM_PORTS'(1) << grant_q;
          cnt_d = cnt_inc_c;
          if (cnt_inc_c == len_q) begin
            state_d = ST_IDLE;
            ptr_d   = grant_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pops are suppressed immediately while reset is held.
  assign pop = reset_L ? pop_c : '0;

  // Arbiter state registers.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= ST_IDLE;
      ptr_q   <= PTR_RST;
      grant_q <= '0;
      cnt_q   <= '0;
      len_q   <= CNT_W'(1);
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  // Mux select/valid follow the pop by one cycle to match FIFO read latency.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      port_mux_q     <= '0;
      valid_mux_q    <= 1'b0;
      grant_active_q <= 1'b0;
    end else begin
      valid_mux_q    <= |pop_c;
      if (|pop_c) port_mux_q <= pop_idx_c;
      grant_active_q <= (state_d == ST_BURST);
    end
  end

  assign port_mux     = port_mux_q;
  assign valid_mux    = valid_mux_q;
  assign grant_active = grant_active_q;

endmodule

// File: tb/tb_round_robin_n.sv
// Randomized and directed bench for round_robin_n against a burst-budget model.
module tb_round_robin_n;

  localparam int NP = 4;
  localparam int BW = 3;

  logic          clk;
  logic          reset_L;
  logic [NP-1:0] request;
  logic [NP*BW-1:0] burst_cfg;
  logic          mode;
  logic          dest_ready;
  logic [NP-1:0] pop;
  logic [1:0]    port_mux;
  logic          valid_mux;
  logic          grant_active;

  int checks = 0;
  int errors = 0;

  round_robin_n #(.NUM_PORTS(NP), .SEL_W(2), .BURST_W(BW)) dut (
    .clk          (clk),
    .reset_L      (reset_L),
    .request      (request),
    .burst_cfg    (burst_cfg),
    .mode         (mode),
    .dest_ready   (dest_ready),
    .pop          (pop),
    .port_mux     (port_mux),
    .valid_mux    (valid_mux),
    .grant_active (grant_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: last winner, current burst owner (-1 none) and pops still owed to it.
  int m_last  = NP - 1;
  int m_owner = -1;
  int m_rem   = 0;
  int e_valid = 0;
  int e_mux   = 0;
  int e_ga    = 0;

  // Per-cycle compare against the model; inputs are stable at the falling edge.
  always @(negedge clk) begin
    int g;
    int len;
    int fld;
    logic [NP-1:0] e_pop;
    if (!reset_L) begin
      chk("rst_valid", int'(valid_mux), 0);
      chk("rst_mux", int'(port_mux), 0);
      chk("rst_ga", int'(grant_active), 0);
      chk("rst_pop", int'(pop), 0);
      m_last = NP - 1; m_owner = -1; m_rem = 0;
      e_valid = 0; e_mux = 0; e_ga = 0;
    end else begin
      chk("valid_model", int'(valid_mux), e_valid);
      chk("mux_model", int'(port_mux), e_mux);
      chk("ga_model", int'(grant_active), e_ga);
      chk("inv_onehot", int'($countones(pop) <= 1), 1);
      chk("inv_req", int'(pop & ~request), 0);
      chk("inv_ready", int'(!dest_ready && pop != '0), 0);
      g = -1;
      if (m_owner >= 0) begin
        if (!request[m_owner]) begin
          m_last = m_owner; m_owner = -1;
        end else if (dest_ready) begin
          g = m_owner;
          m_rem--;
          if (m_rem == 0) begin m_last = m_owner; m_owner = -1; end
        end
      end else if (dest_ready && request != '0) begin
        for (int k = 1; k <= NP; k++) begin
          if (g < 0 && request[(m_last + k) % NP]) g = (m_last + k) % NP;
        end
        fld = int'(burst_cfg[g*BW +: BW]);
        len = mode ? ((fld == 0) ? 1 : fld) : 1;
        if (len > 1) begin m_owner = g; m_rem = len - 1; end
        else m_last = g;
      end
      e_pop = '0;
      if (g >= 0) e_pop[g] = 1'b1;
      chk("pop_model", int'(pop), int'(e_pop));
      e_valid = (g >= 0) ? 1 : 0;
      if (g >= 0) e_mux = g;
      e_ga = (m_owner >= 0) ? 1 : 0;
    end
  end

  // One cycle of stimulus; returns just after the falling edge.
  task automatic cyc(input logic [NP-1:0] req, input logic [NP*BW-1:0] cfg,
                     input logic md, input logic rdy);
    @(posedge clk); #2;
    request = req; burst_cfg = cfg; mode = md; dest_ready = rdy;
    @(negedge clk); #1;
  endtask

  // Reset asserted right now, held across a falling edge, released with no requests.
  task automatic do_reset();
    #1 reset_L = 1'b0;
    #1;
    chk("async_pop", int'(pop), 0);
    chk("async_valid", int'(valid_mux), 0);
    chk("async_ga", int'(grant_active), 0);
    @(negedge clk);
    @(posedge clk); #2;
    request = '0;
    reset_L = 1'b1;
  endtask

  localparam logic [NP*BW-1:0] CFG_P0_3 = {3'd1, 3'd1, 3'd1, 3'd3};
  localparam logic [NP*BW-1:0] CFG_P1_3 = {3'd1, 3'd1, 3'd3, 3'd1};

  initial begin
    logic [3:0] exp_seq [5];
    reset_L = 1'b0; request = '0; burst_cfg = '0; mode = 1'b0; dest_ready = 1'b0;
    #3;
    chk("reset_mux", int'(port_mux), 0);
    chk("reset_valid", int'(valid_mux), 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #2 reset_L = 1'b1;

    // Classic rotation across all four ports.
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < 5; i++) begin
      cyc(4'b1111, '0, 1'b0, 1'b1);
      chk("rot_pop", int'(pop), int'(exp_seq[i]));
      chk("rot_valid", int'(valid_mux), (i == 0) ? 0 : 1);
      if (i > 0) chk("rot_mux", int'(port_mux), (i - 1) % 4);
    end
    cyc(4'b0000, '0, 1'b0, 1'b1);
    chk("rot_tail_mux", int'(port_mux), 0);
    do_reset();

    // Weighted burst: port 0 three pops, port 1 one pop.
    exp_seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0001};
    for (int i = 0; i < 5; i++) begin
      cyc(4'b0011, CFG_P0_3, 1'b1, 1'b1);
      chk("burst_pop", int'(pop), int'(exp_seq[i]));
      chk("burst_ga", int'(grant_active), (i == 1 || i == 2) ? 1 : 0);
    end
    do_reset();

    // Stall mid-burst, then exactly two more pops of port 0.
    cyc(4'b0001, CFG_P0_3, 1'b1, 1'b1); chk("stall_pop0", int'(pop), 1);
    cyc(4'b0001, CFG_P0_3, 1'b1, 1'b0); chk("stall_pop1", int'(pop), 0);
    cyc(4'b0001, CFG_P0_3, 1'b1, 1'b0); chk("stall_pop2", int'(pop), 0);
    chk("stall_valid", int'(valid_mux), 0);
    chk("stall_ga", int'(grant_active), 1);
    cyc(4'b0001, CFG_P0_3, 1'b1, 1'b1); chk("stall_pop3", int'(pop), 1);
    cyc(4'b0001, CFG_P0_3, 1'b1, 1'b1); chk("stall_pop4", int'(pop), 1);
    cyc(4'b0000, CFG_P0_3, 1'b1, 1'b1); chk("stall_end_ga", int'(grant_active), 0);
    do_reset();

    // Request drop abandons the burst; port 2 wins after one empty cycle.
    cyc(4'b0001, CFG_P0_3, 1'b1, 1'b1); chk("drop_pop0", int'(pop), 1);
    cyc(4'b0100, CFG_P0_3, 1'b1, 1'b1); chk("drop_pop1", int'(pop), 0);
    cyc(4'b0100, CFG_P0_3, 1'b1, 1'b1); chk("drop_pop2", int'(pop), 4);
    do_reset();

    // Reset during a port-1 burst; arbitration restarts from port 0.
    cyc(4'b1010, CFG_P1_3, 1'b1, 1'b1); chk("rstmid_pop0", int'(pop), 2);
    cyc(4'b1010, CFG_P1_3, 1'b1, 1'b1); chk("rstmid_pop1", int'(pop), 2);
    request = 4'b1010;
    do_reset();
    cyc(4'b1010, CFG_P1_3, 1'b1, 1'b1); chk("rstmid_after", int'(pop), 2);
    do_reset();

    // Zero burst field behaves as a burst of one.
    for (int i = 0; i < 4; i++) begin
      cyc(4'b0001, '0, 1'b1, 1'b1);
      chk("zero_pop", int'(pop), 1);
      chk("zero_ga", int'(grant_active), 0);
    end

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      cyc(NP'($urandom & $urandom), (NP*BW)'($urandom), 1'($urandom),
          1'(($urandom % 4) != 0));
      if ($urandom_range(0, 199) == 0) do_reset();
    end

    @(negedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
